cram_arbiter: RTL and testbench
===============================

CRAM_ARBITER -- requirements
Module: cram_arbiter

Interface
Parameters:
REQ-001 SHALL provide parameter ADDR_W, default 17: cart RAM byte-address width.

Ports:
REQ-002 SHALL have port clk_sys, input, 1: system clock, rising edge; the block has one clock.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port ce, input, 1: CPU access strobe (speed-adjusted CPU clock enable).
REQ-005 SHALL have port cpu_rd, input, 1: CPU cart-RAM read.
REQ-006 SHALL have port cpu_wr, input, 1: CPU cart-RAM write.
REQ-007 SHALL have port cpu_addr, input, ADDR_W: mapper-translated byte address (cram_addr).
REQ-008 SHALL have port cpu_di, input, 8: CPU write data.
REQ-009 SHALL have port cpu_do, output, 8: CPU read data.
REQ-010 SHALL have port ram_enabled, input, 1: mapper RAM-enable; gates CPU writes.
REQ-011 SHALL have port bk_req, input, 1: backup word request, level, held until bk_ack.
REQ-012 SHALL have port bk_we, input, 1: 1 = backup write, 0 = backup read; sampled at accept.
REQ-013 SHALL have port bk_addr, input, ADDR_W-1: backup word address.
REQ-014 SHALL have port bk_di, input, 16: backup write word.
REQ-015 SHALL have port bk_do, output, 16: backup read word.
REQ-016 SHALL have port bk_ack, output, 1: one-cycle completion pulse.
REQ-017 SHALL have port busy, output, 1: backup transfer in progress.
REQ-018 SHALL have port ram_addr, output, ADDR_W: RAM byte address.
REQ-019 SHALL have port ram_di, output, 8: RAM write data.
REQ-020 SHALL have port ram_we, output, 1: RAM write enable.
REQ-021 SHALL have port ram_do, input, 8: RAM read data; synchronous RAM, valid 1 cycle after address.

Function
REQ-022 SHALL define the CPU cycle as cpu_sel = ce & (cpu_rd | cpu_wr); CPU has absolute priority.
REQ-023 SHALL, when cpu_sel is high, drive ram_addr = cpu_addr, ram_di = cpu_di and ram_we = cpu_wr & ram_enabled combinationally in that same cycle.
REQ-024 SHALL, on a CPU read, load cpu_do from ram_do in the cycle following the cpu_sel cycle and hold cpu_do until the next CPU read.
REQ-025 SHALL sequence backup transfers with an FSM of states IDLE, LO, HI, FIN, ACK.
REQ-026 SHALL, in IDLE with bk_req = 1, latch bk_addr, bk_di and bk_we, then go to LO.
REQ-027 SHALL issue byte address {bk_addr,1'b0} (byte = bk_di[7:0]) in LO and {bk_addr,1'b1} (byte = bk_di[15:8]) in HI.
REQ-028 SHALL treat LO/HI as issued only in a cycle without cpu_sel; a stolen cycle holds the state and retries next cycle.
REQ-029 SHALL, for a write, set ram_we = 1 in each issue cycle and go HI -> ACK.
REQ-030 SHALL, for a read, set ram_we = 0, go HI -> FIN -> ACK, and capture ram_do into bk_do[7:0] (or [15:8]) exactly one cycle after the respective issue cycle, regardless of a CPU steal in the capture cycle.
REQ-031 SHALL not let FIN wait on the CPU; FIN always advances to ACK next cycle.
REQ-032 SHALL pulse bk_ack = 1 for exactly one cycle in ACK, with bk_do stable from ACK until the next accept, then return to IDLE.
REQ-033 SHALL start a new transfer after ACK if bk_req is still high in IDLE; requesters deassert bk_req on bk_ack.
REQ-034 SHALL assert busy in LO, HI, FIN and ACK.
REQ-035 SHALL hold ram_we = 0 when neither the CPU nor an issue cycle owns the port.
REQ-036 SHALL not let backup writes depend on ram_enabled.

Reset
REQ-037 SHALL, on reset assertion, asynchronously force state IDLE, bk_ack 0, busy 0, bk_do 16'h0000, cpu_do 8'hFF and latched registers 0.
REQ-038 SHALL, on reset mid-transfer, issue no further RAM writes and emit no bk_ack; a pending request is re-accepted from IDLE after release.

Verification
REQ-039 SHALL verify: bk write addr 16'h0010, data 16'hBEEF, CPU idle -> byte 0x20 = EF, byte 0x21 = BE, bk_ack 3 cycles after accept.
REQ-040 SHALL verify: bk read of word 0x10 after the write -> bk_do = 16'hBEEF at bk_ack, 4 cycles after accept.
REQ-041 SHALL verify: CPU write 0x55 to 0x0021 with ce in the HI issue cycle -> CPU write occurs, HI retries next cycle, final byte 0x21 = BE, bk_ack delayed 1 cycle.
REQ-042 SHALL verify: CPU write with ram_enabled = 0 -> ram_we stays 0, RAM unchanged.
REQ-043 SHALL verify: reset asserted in HI of a write -> byte 0x21 not written, no bk_ack, cpu_do = FF.
REQ-044 SHALL verify: CPU read 0x0100 (RAM = 0x3C) during backup FIN -> cpu_do = 3C next cycle, bk_do unaffected.

Source files
------------

// File: rtl/cram_arbiter.sv
// Cart RAM port arbiter: the CPU owns the single-port RAM whenever it strobes;
// a two-byte backup transfer engine uses the cycles the CPU leaves free.
module cram_arbiter #(
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ce,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_di,
    output logic [7:0]        cpu_do,
    input  logic              ram_enabled,
    input  logic              bk_req,
    input  logic              bk_we,
    input  logic [ADDR_W-2:0] bk_addr,
    input  logic [15:0]       bk_di,
    output logic [15:0]       bk_do,
    output logic              bk_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_di,
    output logic              ram_we,
    input  logic [7:0]        ram_do
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_FIN,
        ST_ACK
    } state_t;

    state_t            state_q;
    logic [ADDR_W-2:0] addr_q;
    logic [15:0]       wdata_q;
    logic              we_q;
    logic [15:0]       bk_do_q;
    logic              bk_ack_q;
    logic              busy_q;
    logic              cap_lo_q;
    logic              cap_hi_q;
    logic              cpu_rd_pend_q;
    logic [7:0]        cpu_do_q;

    logic              cpu_sel;
    logic              issue;
    logic              issue_hi;

    assign cpu_sel  = ce & (cpu_rd | cpu_wr);
    assign issue    = ~cpu_sel & ((state_q == ST_LO) | (state_q == ST_HI));
    assign issue_hi = (state_q == ST_HI);

    always_comb begin
        ram_addr = cpu_addr;
        ram_di   = cpu_di;
        ram_we   = 1'b0;
        if (cpu_sel) begin
            ram_we = cpu_wr & ram_enabled;
        end else if (issue) begin
            ram_addr = {addr_q, issue_hi};
            ram_di   = issue_hi ? wdata_q[15:8] : wdata_q[7:0];
            ram_we   = we_q;
        end
    end

    // Capture flags trail each read issue by one cycle, so a CPU steal in the
    // capture cycle cannot delay or corrupt the backup read data.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            bk_do_q  <= '0;
            bk_ack_q <= 1'b0;
            busy_q   <= 1'b0;
            cap_lo_q <= 1'b0;
            cap_hi_q <= 1'b0;
        end else begin
            bk_ack_q <= 1'b0;
            cap_lo_q <= 1'b0;
            cap_hi_q <= 1'b0;
            if (cap_lo_q) bk_do_q[7:0]  <= ram_do;
            if (cap_hi_q) bk_do_q[15:8] <= ram_do;
            case (state_q)
                ST_IDLE: begin
                    if (bk_req) begin
                        addr_q  <= bk_addr;
                        wdata_q <= bk_di;
                        we_q    <= bk_we;
                        busy_q  <= 1'b1;
                        state_q <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (!cpu_sel) begin
                        cap_lo_q <= ~we_q;
                        state_q  <= ST_HI;
                    end
                end
                ST_HI: begin
                    if (!cpu_sel) begin
                        if (we_q) begin
                            bk_ack_q <= 1'b1;
                            state_q  <= ST_ACK;
                        end else begin
                            cap_hi_q <= 1'b1;
                            state_q  <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    bk_ack_q <= 1'b1;
                    state_q  <= ST_ACK;
                end
                ST_ACK: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cpu_rd_pend_q <= 1'b0;
            cpu_do_q      <= 8'hFF;
        end else begin
            cpu_rd_pend_q <= cpu_sel & cpu_rd;
            if (cpu_rd_pend_q) cpu_do_q <= ram_do;
        end
    end

    // Read data is visible in the cycle after the read and held afterwards.
    assign cpu_do = cpu_rd_pend_q ? ram_do : cpu_do_q;
    assign bk_do  = bk_do_q;
    assign bk_ack = bk_ack_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_cram_arbiter.sv
// Directed bench for cram_arbiter with a behavioural synchronous byte RAM.
module tb_cram_arbiter;

    logic        clk_sys;
    logic        reset;
    logic        ce;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [16:0] cpu_addr;
    logic [7:0]  cpu_di;
    logic [7:0]  cpu_do;
    logic        ram_enabled;
    logic        bk_req;
    logic        bk_we;
    logic [15:0] bk_addr;
    logic [15:0] bk_di;
    logic [15:0] bk_do;
    logic        bk_ack;
    logic        busy;
    logic [16:0] ram_addr;
    logic [7:0]  ram_di;
    logic        ram_we;
    logic [7:0]  ram_do;

    logic [7:0]  mem [0:(1<<17)-1];
    int          ack_cnt = 0;
    int          vectors = 0;
    int          errors  = 0;

    cram_arbiter #(.ADDR_W(17)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ce         (ce),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_di     (cpu_di),
        .cpu_do     (cpu_do),
        .ram_enabled(ram_enabled),
        .bk_req     (bk_req),
        .bk_we      (bk_we),
        .bk_addr    (bk_addr),
        .bk_di      (bk_di),
        .bk_do      (bk_do),
        .bk_ack     (bk_ack),
        .busy       (busy),
        .ram_addr   (ram_addr),
        .ram_di     (ram_di),
        .ram_we     (ram_we),
        .ram_do     (ram_do)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_di;
        ram_do <= mem[ram_addr];
    end

    always @(posedge clk_sys) begin
        if (bk_ack) ack_cnt <= ack_cnt + 1;
    end

    task automatic bk_start(input logic we, input logic [15:0] addr, input logic [15:0] di);
        bk_we   = we;
        bk_addr = addr;
        bk_di   = di;
        bk_req  = 1'b1;
    endtask

    task automatic cpu_idle();
        ce     = 1'b0;
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
    endtask

    // Returns the cycle index (relative to the accept cycle) of bk_ack, or -1.
    task automatic wait_ack(input int start, input bit drop, output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_sys);
            if (bk_ack) begin
                lat = start + i;
                if (drop) bk_req = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        vectors++; if (bk_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", bk_ack); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (bk_do !== 16'h0000) begin errors++; $display("FAIL rst_bk_do: got %h want 0000", bk_do); end
        vectors++; if (cpu_do !== 8'hFF) begin errors++; $display("FAIL rst_cpu_do: got %h want ff", cpu_do); end
        vectors++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
    endtask

    task automatic test_bk_write();
        int lat;
        bk_start(1'b1, 16'h0010, 16'hBEEF);
        wait_ack(0, 1'b1, lat);
        vectors++; if (lat !== 3) begin errors++; $display("FAIL bkw_lat: got %0d want 3", lat); end
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL bkw_busy_ack: got %b want 1", busy); end
        vectors++; if (mem[17'h20] !== 8'hEF) begin errors++; $display("FAIL bkw_lo: got %h want ef", mem[17'h20]); end
        vectors++; if (mem[17'h21] !== 8'hBE) begin errors++; $display("FAIL bkw_hi: got %h want be", mem[17'h21]); end
        @(negedge clk_sys);
        vectors++; if (busy !== 1'b0 || bk_ack !== 1'b0) begin errors++; $display("FAIL bkw_done: got busy %b ack %b want 0 0", busy, bk_ack); end
    endtask

    task automatic test_bk_read();
        int lat;
        bk_start(1'b0, 16'h0010, 16'h0000);
        wait_ack(0, 1'b1, lat);
        vectors++; if (lat !== 4) begin errors++; $display("FAIL bkr_lat: got %0d want 4", lat); end
        vectors++; if (bk_do !== 16'hBEEF) begin errors++; $display("FAIL bkr_data: got %h want beef", bk_do); end
        repeat (3) @(negedge clk_sys);
        vectors++; if (bk_do !== 16'hBEEF) begin errors++; $display("FAIL bkr_hold: got %h want beef", bk_do); end
    endtask

    task automatic test_cpu_rw();
        ce = 1'b1; cpu_wr = 1'b1; cpu_addr = 17'h00100; cpu_di = 8'h3C;
        #1;
        vectors++; if (ram_we !== 1'b1 || ram_addr !== 17'h00100 || ram_di !== 8'h3C) begin
            errors++; $display("FAIL cpuw_port: got we %b addr %h di %h want 1 00100 3c", ram_we, ram_addr, ram_di);
        end
        @(negedge clk_sys);
        cpu_idle();
        #1;
        vectors++; if (ram_we !== 1'b0) begin errors++; $display("FAIL idle_we: got %b want 0", ram_we); end
        vectors++; if (mem[17'h100] !== 8'h3C) begin errors++; $display("FAIL cpuw_mem: got %h want 3c", mem[17'h100]); end
        @(negedge clk_sys);
        ce = 1'b1; cpu_rd = 1'b1; cpu_addr = 17'h00020;
        @(negedge clk_sys);
        cpu_idle();
        vectors++; if (cpu_do !== 8'hEF) begin errors++; $display("FAIL cpur_data: got %h want ef", cpu_do); end
        repeat (2) @(negedge clk_sys);
        vectors++; if (cpu_do !== 8'hEF) begin errors++; $display("FAIL cpur_hold: got %h want ef", cpu_do); end
    endtask

    task automatic test_cpu_steal_hi();
        int lat;
        bk_start(1'b1, 16'h0010, 16'hBEEF);
        repeat (2) @(negedge clk_sys);
        ce = 1'b1; cpu_wr = 1'b1; cpu_addr = 17'h00021; cpu_di = 8'h55;
        #1;
        vectors++; if (ram_we !== 1'b1 || ram_addr !== 17'h00021 || ram_di !== 8'h55) begin
            errors++; $display("FAIL steal_port: got we %b addr %h di %h want 1 00021 55", ram_we, ram_addr, ram_di);
        end
        @(negedge clk_sys);
        cpu_idle();
        vectors++; if (mem[17'h21] !== 8'h55) begin errors++; $display("FAIL steal_cpuw: got %h want 55", mem[17'h21]); end
        vectors++; if (bk_ack !== 1'b0) begin errors++; $display("FAIL steal_early_ack: got %b want 0", bk_ack); end
        wait_ack(3, 1'b1, lat);
        vectors++; if (lat !== 4) begin errors++; $display("FAIL steal_lat: got %0d want 4", lat); end
        vectors++; if (mem[17'h21] !== 8'hBE) begin errors++; $display("FAIL steal_hi: got %h want be", mem[17'h21]); end
        vectors++; if (mem[17'h20] !== 8'hEF) begin errors++; $display("FAIL steal_lo: got %h want ef", mem[17'h20]); end
        @(negedge clk_sys);
    endtask

    task automatic test_wr_disabled();
        ram_enabled = 1'b0;
        ce = 1'b1; cpu_wr = 1'b1; cpu_addr = 17'h00021; cpu_di = 8'h99;
        #1;
        vectors++; if (ram_we !== 1'b0) begin errors++; $display("FAIL dis_we: got %b want 0", ram_we); end
        @(negedge clk_sys);
        cpu_idle();
        ram_enabled = 1'b1;
        vectors++; if (mem[17'h21] !== 8'hBE) begin errors++; $display("FAIL dis_mem: got %h want be", mem[17'h21]); end
    endtask

    task automatic test_cpu_rd_fin();
        int lat;
        bk_start(1'b0, 16'h0010, 16'h0000);
        repeat (3) @(negedge clk_sys);
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL fin_busy: got %b want 1", busy); end
        ce = 1'b1; cpu_rd = 1'b1; cpu_addr = 17'h00100;
        wait_ack(3, 1'b1, lat);
        cpu_idle();
        vectors++; if (lat !== 4) begin errors++; $display("FAIL fin_lat: got %0d want 4", lat); end
        vectors++; if (cpu_do !== 8'h3C) begin errors++; $display("FAIL fin_cpu_do: got %h want 3c", cpu_do); end
        vectors++; if (bk_do !== 16'hBEEF) begin errors++; $display("FAIL fin_bk_do: got %h want beef", bk_do); end
        @(negedge clk_sys);
        vectors++; if (cpu_do !== 8'h3C || bk_do !== 16'hBEEF) begin
            errors++; $display("FAIL fin_hold: got %h %h want 3c beef", cpu_do, bk_do);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        ram_enabled = 1'b0;
        bk_start(1'b1, 16'h0030, 16'h1111);
        wait_ack(0, 1'b0, lat);
        vectors++; if (lat !== 3) begin errors++; $display("FAIL b2b_lat1: got %0d want 3", lat); end
        bk_addr = 16'h0031; bk_di = 16'hA5C3;
        wait_ack(3, 1'b1, lat);
        ram_enabled = 1'b1;
        vectors++; if (lat !== 7) begin errors++; $display("FAIL b2b_lat2: got %0d want 7", lat); end
        vectors++; if (mem[17'h60] !== 8'h11 || mem[17'h61] !== 8'h11) begin
            errors++; $display("FAIL b2b_word1: got %h%h want 1111", mem[17'h61], mem[17'h60]);
        end
        vectors++; if (mem[17'h62] !== 8'hC3 || mem[17'h63] !== 8'hA5) begin
            errors++; $display("FAIL b2b_word2: got %h%h want a5c3", mem[17'h63], mem[17'h62]);
        end
        @(negedge clk_sys);
    endtask

    task automatic test_reset_mid();
        int lat;
        int ack0;
        ce = 1'b1; cpu_wr = 1'b1; cpu_addr = 17'h00021; cpu_di = 8'h77;
        @(negedge clk_sys);
        cpu_idle();
        bk_start(1'b1, 16'h0010, 16'h1234);
        repeat (2) @(negedge clk_sys);
        ack0 = ack_cnt;
        reset = 1'b1;
        #1;
        vectors++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rmid_we: got %b want 0", ram_we); end
        vectors++; if (busy !== 1'b0 || bk_ack !== 1'b0) begin errors++; $display("FAIL rmid_busy_ack: got %b %b want 0 0", busy, bk_ack); end
        vectors++; if (cpu_do !== 8'hFF) begin errors++; $display("FAIL rmid_cpu_do: got %h want ff", cpu_do); end
        vectors++; if (bk_do !== 16'h0000) begin errors++; $display("FAIL rmid_bk_do: got %h want 0000", bk_do); end
        repeat (2) @(negedge clk_sys);
        vectors++; if (mem[17'h21] !== 8'h77) begin errors++; $display("FAIL rmid_hi: got %h want 77", mem[17'h21]); end
        vectors++; if (mem[17'h20] !== 8'h34) begin errors++; $display("FAIL rmid_lo: got %h want 34", mem[17'h20]); end
        vectors++; if (ack_cnt !== ack0) begin errors++; $display("FAIL rmid_noack: got %0d acks want %0d", ack_cnt, ack0); end
        reset = 1'b0;
        wait_ack(0, 1'b1, lat);
        vectors++; if (lat !== 3) begin errors++; $display("FAIL rmid_reaccept: got %0d want 3", lat); end
        vectors++; if (mem[17'h21] !== 8'h12) begin errors++; $display("FAIL rmid_redo: got %h want 12", mem[17'h21]); end
        @(negedge clk_sys);
    endtask

    initial begin
        reset = 1'b1;
        cpu_idle();
        cpu_addr    = '0;
        cpu_di      = '0;
        ram_enabled = 1'b1;
        bk_req      = 1'b0;
        bk_we       = 1'b0;
        bk_addr     = '0;
        bk_di       = '0;
        repeat (2) @(negedge clk_sys);
        test_reset();
        reset = 1'b0;
        @(negedge clk_sys);
        test_bk_write();
        test_bk_read();
        test_cpu_rw();
        test_cpu_steal_hi();
        test_wr_disabled();
        test_cpu_rd_fin();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
